// File: rtl/light_hash_feeder.sv
// Frames a ready/valid byte stream into light_hash head/message/tail strobes
// and returns the digest on a ready/valid port. Option: LH_FEED_TIMEOUT_EN.
module light_hash_feeder #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_byte,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       hash_byte,
    output logic             hash_valid,
    output logic [1:0]       hash_state,
    input  logic             hash_busy,
    input  logic [63:0]      hash_digest,
    input  logic             hash_digest_ready,
    output logic [63:0]      d_out,
    output logic [LEN_W-1:0] d_len,
    output logic             d_valid,
    input  logic             d_ready,
    output logic             d_err
);

    typedef enum logic [3:0] {
        IDLE, HEAD, GUARD, WAIT, MSG, TAIL, TGUARD, TWAIT, OUT
    } state_t;

    localparam logic [1:0] HS_HEAD = 2'b00;
    localparam logic [1:0] HS_TAIL = 2'b01;
    localparam logic [1:0] HS_MSG  = 2'b10;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         hs_q, hs_d;
    logic [7:0]         hb_q, hb_d;
    logic [63:0]        dout_q, dout_d;
    logic [LEN_W-1:0]   dlen_q, dlen_d;
    logic               hv;
    logic               sr;

`ifdef LH_FEED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          derr_q, derr_d;
`endif

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        len_d   = len_q;
        hs_d    = hs_q;
        hb_d    = hb_q;
        dout_d  = dout_q;
        dlen_d  = dlen_q;
        hv      = 1'b0;
        sr      = 1'b0;
`ifdef LH_FEED_TIMEOUT_EN
        cnt_d   = cnt_q;
        derr_d  = derr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    len_d   = '0;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                hv      = 1'b1;
                hs_d    = HS_HEAD;
                ret_d   = MSG;
                state_d = GUARD;
            end
            // core raises busy one cycle after the strobe
            GUARD: state_d = WAIT;
            WAIT: begin
                if (!hash_busy) state_d = ret_q;
            end
            MSG: begin
                sr = 1'b1;
                if (s_valid) begin
                    hv   = 1'b1;
                    hs_d = HS_MSG;
                    hb_d = s_byte;
                    if (len_q != {LEN_W{1'b1}}) len_d = len_q + LEN_W'(1);
                    ret_d   = s_last ? TAIL : MSG;
                    state_d = GUARD;
                end
            end
            TAIL: begin
                hv      = 1'b1;
                hs_d    = HS_TAIL;
                state_d = TGUARD;
            end
            TGUARD: begin
`ifdef LH_FEED_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = TWAIT;
            end
            TWAIT: begin
                if (hash_digest_ready) begin
                    dout_d  = hash_digest;
                    dlen_d  = len_q;
`ifdef LH_FEED_TIMEOUT_EN
                    derr_d  = 1'b0;
`endif
                    state_d = OUT;
                end
`ifdef LH_FEED_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    dout_d  = '0;
                    dlen_d  = len_q;
                    derr_d  = 1'b1;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            OUT: begin
                if (d_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ret_q   <= MSG;
            len_q   <= '0;
            hs_q    <= 2'b11;
            hb_q    <= '0;
            dout_q  <= '0;
            dlen_q  <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            len_q   <= len_d;
            hs_q    <= hs_d;
            hb_q    <= hb_d;
            dout_q  <= dout_d;
            dlen_q  <= dlen_d;
        end
    end

`ifdef LH_FEED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            derr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            derr_q <= derr_d;
        end
    end
    assign d_err = derr_q;
`else
    assign d_err = 1'b0;
`endif

    // hs_d/hb_d equal the held values whenever no strobe is issued
    assign hash_valid = hv;
    assign hash_state = hs_d;
    assign hash_byte  = hb_d;
    assign s_ready    = sr;
    assign d_valid    = (state_q == OUT);
    assign d_out      = dout_q;
    assign d_len      = dlen_q;

endmodule

// File: tb/tb_light_hash_feeder.sv
// Directed bench for light_hash_feeder with a behavioural stub of the core.
module tb_light_hash_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_byte;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  hash_byte;
    logic        hash_valid;
    logic [1:0]  hash_state;
    logic        hash_busy;
    logic [63:0] hash_digest;
    logic        hash_digest_ready;
    logic [63:0] d_out;
    logic [15:0] d_len;
    logic        d_valid;
    logic        d_ready;
    logic        d_err;

    light_hash_feeder #(.LEN_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .hash_byte(hash_byte), .hash_valid(hash_valid), .hash_state(hash_state),
        .hash_busy(hash_busy), .hash_digest(hash_digest),
        .hash_digest_ready(hash_digest_ready),
        .d_out(d_out), .d_len(d_len), .d_valid(d_valid), .d_ready(d_ready),
        .d_err(d_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // stub core: busy for busy_n cycles starting one cycle after a strobe,
    // digest_ready one cycle wide a few cycles after the tail
    int          busy_n = 2;
    int          bcnt;
    int          dcnt;
    bit          no_digest = 1'b0;
    logic [63:0] cur_dig = '0;

    always @(posedge clk) begin
        if (rst) begin
            bcnt              <= 0;
            dcnt              <= 0;
            hash_busy         <= 1'b0;
            hash_digest_ready <= 1'b0;
            hash_digest       <= '0;
        end else begin
            if (hash_valid) bcnt <= busy_n;
            else if (bcnt != 0) bcnt <= bcnt - 1;
            hash_busy <= (bcnt != 0);
            if (hash_valid && hash_state == 2'b01) dcnt <= 3;
            else if (dcnt != 0) dcnt <= dcnt - 1;
            hash_digest_ready <= (dcnt == 1) && !no_digest;
            hash_digest       <= (dcnt == 1) ? cur_dig : ~cur_dig;
        end
    end

    // strobe monitor
    int       n_head, n_msg, n_tail, n_wide;
    logic     prev_hv = 1'b0;
    byte      q[$];
    int       cyc = 0;
    int       tail_cyc = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_hv <= hash_valid && !rst;
        if (!rst && hash_valid) begin
            if (prev_hv) n_wide <= n_wide + 1;
            case (hash_state)
                2'b00: n_head <= n_head + 1;
                2'b10: begin
                    n_msg <= n_msg + 1;
                    q.push_back(hash_byte);
                end
                2'b01: begin
                    n_tail   <= n_tail + 1;
                    tail_cyc <= cyc;
                end
                default: n_wide <= n_wide + 1;
            endcase
        end
    end

    // busy-window monitor
    bit   bmon = 1'b0;
    logic prev_busy = 1'b0;
    int   bviol = 0;
    int   bsamp = 0;

    always @(negedge clk) begin
        prev_busy <= hash_busy;
        if (bmon && (hash_busy || prev_busy) && (hash_valid || s_ready))
            bviol <= bviol + 1;
        if (bmon && hash_busy) bsamp <= bsamp + 1;
    end

    typedef struct {
        string       msg;
        bit          gap;
        int          hold;
        logic [63:0] dig;
        int          len;
    } vec_t;

    vec_t tv[4];

    task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        n_head = 0;
        n_msg  = 0;
        n_tail = 0;
        n_wide = 0;
        q.delete();
    endtask

    task automatic send(string m, bit gap, int nb, bit last_en);
        int budget;
        for (int i = 0; i < nb; i++) begin
            if (gap) repeat ($urandom_range(0, 5)) @(negedge clk);
            s_byte  = m[i];
            s_last  = last_en && (i == nb - 1);
            s_valid = 1'b1;
            budget  = 0;
            while (!s_ready && budget < 300) begin
                @(negedge clk);
                budget++;
            end
            if (!s_ready) begin
                check64("send_timeout", 64'(s_ready), 64'd1);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic sink(int hold, logic [63:0] dig, int len);
        int budget;
        int bad;
        d_ready = (hold == 0);
        budget  = 0;
        while (!d_valid && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check64("d_valid_seen", 64'(d_valid), 64'd1);
        check64("d_out", d_out, dig);
        check64("d_len", 64'(d_len), 64'(len));
        check64("d_err", 64'(d_err), 64'd0);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            if (!d_valid || d_out !== dig || s_ready) bad++;
            @(negedge clk);
        end
        check64("stall_stable", 64'(bad), 64'd0);
        d_ready = 1'b1;
        @(negedge clk);
        check64("d_valid_once", 64'(d_valid), 64'd0);
    endtask

    task automatic run_entry(int k);
        vec_t v;
        int   mism;
        v       = tv[k];
        cur_dig = v.dig;
        clear_mon();
        fork
            send(v.msg, v.gap, v.msg.len(), 1'b1);
            sink(v.hold, v.dig, v.len);
        join
        check64("head_pulses", 64'(n_head), 64'd1);
        check64("msg_pulses", 64'(n_msg), 64'(v.len));
        check64("tail_pulses", 64'(n_tail), 64'd1);
        check64("wide_pulses", 64'(n_wide), 64'd0);
        mism = 0;
        if (q.size() != v.msg.len()) mism++;
        else for (int i = 0; i < q.size(); i++) if (q[i] !== v.msg[i]) mism++;
        check64("msg_bytes", 64'(mism), 64'd0);
    endtask

    task automatic check_reset_state(string tag);
        check64({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check64({tag, "_hash_valid"}, 64'(hash_valid), 64'd0);
        check64({tag, "_hash_state"}, 64'(hash_state), 64'd3);
        check64({tag, "_hash_byte"}, 64'(hash_byte), 64'd0);
        check64({tag, "_d_valid"}, 64'(d_valid), 64'd0);
        check64({tag, "_d_out"}, d_out, 64'd0);
        check64({tag, "_d_len"}, 64'(d_len), 64'd0);
        check64({tag, "_d_err"}, 64'(d_err), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{"H4rdw4r3_Tr0j4n",      1'b0, 0,  64'h5aecbf4f5fe467bc, 15};
        tv[1] = '{"3.141592653589793238", 1'b1, 0,  64'hf9e317d512022e21, 20};
        tv[2] = '{"AlessandroAndGiacomo", 1'b0, 10, 64'he19e79abcdf021f1, 20};
        tv[3] = '{"AlessandroandGiacomo", 1'b0, 10, 64'h48f63b14b5c40a5a, 20};

        rst     = 1'b1;
        s_byte  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        d_ready = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_reset_state("init");
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 4; k++) run_entry(k);

        // reset after five bytes of a message
        clear_mon();
        cur_dig = tv[0].dig;
        send(tv[0].msg, 1'b0, 5, 1'b0);
        check64("pre_rst_msgs", 64'(n_msg), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check64("no_tail_after_rst", 64'(n_tail), 64'd0);
        run_entry(0);

        // slow core: busy for 7 cycles per strobe
        busy_n  = 7;
        cur_dig = 64'h0123456789abcdef;
        clear_mon();
        bmon = 1'b1;
        fork
            send("Gc", 1'b0, 2, 1'b1);
            sink(0, 64'h0123456789abcdef, 2);
        join
        bmon = 1'b0;
        @(negedge clk);
        check64("busy_violations", 64'(bviol), 64'd0);
        check64("busy_seen", 64'(bsamp >= 21), 64'd1);
        check64("busy_msg_pulses", 64'(n_msg), 64'd2);
        busy_n = 2;

`ifdef LH_FEED_TIMEOUT_EN
        begin
            int budget;
            no_digest = 1'b1;
            cur_dig   = 64'hffffffffffffffff;
            d_ready   = 1'b1;
            clear_mon();
            send("Z", 1'b0, 1, 1'b1);
            budget = 0;
            while (!d_valid && budget < 200) begin
                @(negedge clk);
                budget++;
            end
            check64("to_d_valid", 64'(d_valid), 64'd1);
            check64("to_latency", 64'(cyc - tail_cyc), 64'd18);
            check64("to_d_err", 64'(d_err), 64'd1);
            check64("to_d_out", d_out, 64'd0);
            check64("to_d_len", 64'(d_len), 64'd1);
            @(negedge clk);
            no_digest = 1'b0;
        end
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/light_hash_feeder.md
Name: light_hash_feeder

Overview:
- Front end that drives the light_hash core's byte-level protocol from a ready/valid byte stream.
- Frames each stream packet into head → message bytes → tail, paced by the core's busy flag.
- Captures the 64-bit digest and presents it on a ready/valid output port.
- Sits between the message source (DMA/UART) and light_hash; replaces the bench-driven sequencing.

Parameters:
- LEN_W, 16, width of per-message byte counter; saturates at 2^LEN_W-1
- TIMEOUT, 1024, cycles allowed for digest_ready after tail (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_byte  in  8  message byte from upstream
- s_valid  in  1  s_byte/s_last valid
- s_last  in  1  marks the final byte of a message; every message is ≥1 byte
- s_ready  out  1  byte accepted when s_valid&s_ready at a rising edge
- hash_byte  out  8  to core message_byte
- hash_valid  out  1  to core message_valid; single-cycle pulse
- hash_state  out  2  to core state: 00 head, 01 tail, 10 message
- hash_busy  in  1  core next_byte; high while core processes a byte
- hash_digest  in  64  core digest
- hash_digest_ready  in  1  core digest_ready
- d_out  out  64  captured digest
- d_len  out  LEN_W  message byte count for d_out
- d_valid  out  1  d_out/d_len valid
- d_ready  in  1  downstream accept
- d_err  out  1  timeout flag, qualified by d_valid; constant 0 without the optional feature

Behaviour:
- Reset values:
  - s_ready=0, hash_valid=0, hash_state=2'b11, hash_byte=0
  - d_valid=0, d_out=0, d_len=0, d_err=0
  - FSM returns to IDLE.
- rst mid-message: abort immediately, no tail issued, counter cleared. The core must be reset alongside.
- FSM states: IDLE, HEAD, GUARD, WAIT, MSG, TAIL, TGUARD, TWAIT, OUT.
- IDLE:
  - s_valid=1 → HEAD (byte not yet consumed); len cleared.
- HEAD:
  - hash_valid=1, hash_state=00 for exactly one cycle.
  - next=GUARD, ret=MSG.
- GUARD:
  - one cycle; hash_busy ignored because the core asserts busy one cycle late.
  - → WAIT.
- WAIT:
  - hold while hash_busy=1.
  - hash_busy=0 → ret.
- MSG:
  - s_ready=1. On s_valid: hash_valid=1, hash_state=10, hash_byte=s_byte (all same cycle).
  - len+=1, saturating. last_q←s_last.
  - next=GUARD, with ret=TAIL if s_last, else MSG.
  - No s_valid → stay in MSG, hash_valid=0.
- s_ready is high only in MSG, so at most one byte is accepted per core round trip; no internal buffer.
- TAIL:
  - hash_valid=1, hash_state=01 for one cycle.
  - → TGUARD (one cycle) → TWAIT.
- TWAIT:
  - hash_digest_ready=1 → capture d_out←hash_digest and d_len←len, d_err=0 → OUT.
- OUT:
  - d_valid=1 and held stable until d_ready. The transfer clears d_valid → IDLE.
  - d_ready already high on entry: d_valid lasts exactly one cycle.
  - s_ready=0 throughout OUT; the next message waits.
- hash_state keeps its last driven value when hash_valid=0 (core ignores it).
- Latency, digest_ready→d_valid: 1 cycle.
- Head is issued no earlier than the cycle after IDLE sees s_valid.

Optional Feature:
- Macro: LH_FEED_TIMEOUT_EN.
- Defined:
  - a counter runs in TWAIT.
  - If hash_digest_ready stays low for TIMEOUT cycles → OUT with d_out=0, d_err=1, d_len=len.
  - The counter clears on entry to TWAIT.
- Undefined:
  - TWAIT waits indefinitely; d_err tied 0; no counter logic.

Test Plan:
- Stream "H4rdw4r3_Tr0j4n" (15 bytes, last on 'n'), d_ready=1 → d_valid once; d_out=64'h5aecbf4f5fe467bc, d_len=15, d_err=0.
- Stream "3.141592653589793238" with s_valid gapped randomly (0–5 idle cycles) → d_out=64'hf9e317d512022e21, d_len=20. Exactly 1 head, 20 message and 1 tail pulses, each hash_valid one cycle wide.
- Back-to-back "AlessandroAndGiacomo" then "AlessandroandGiacomo", d_ready held low 10 cycles each:
  - d_out stable while stalled.
  - Outputs 64'he19e79abcdf021f1 then 64'h48f63b14b5c40a5a.
  - s_ready=0 during OUT.
- Assert rst for one cycle after 5 bytes of a message → next cycle all outputs at reset values, no tail pulse. A following full "H4rdw4r3_Tr0j4n" still yields 64'h5aecbf4f5fe467bc.
- Stub core holding hash_busy=1 for 7 cycles per byte → no new hash_valid and s_ready=0 until the cycle after busy falls.
- With LH_FEED_TIMEOUT_EN and TIMEOUT=16, stub core never raises digest_ready → d_valid at 16 cycles after TWAIT entry, d_err=1, d_out=0.
